// File: rtl/ram_bank_arbiter.sv
// Dual-bank scratch RAM arbiter: parallel access on distinct banks, per-bank
// round-robin on collisions, registered bank strobes, fixed-latency read return.
`timescale 1ns/1ps

module ram_bank_lane #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_hit,
  input  logic                  b_hit,
  input  logic                  a_we,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_win,
  output logic                  b_win,
  output logic                  conflict,
  output logic                  en,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  rvalid,
  output logic                  rd_owner
);
  localparam int STAGES = 2;

  logic              prio;
  logic              grant;
  logic              sel_we;
  logic              rd_go;
  logic [STAGES:1]   vld_pipe;
  logic [STAGES:1]   own_pipe;

  assign conflict = a_hit & b_hit;
  assign a_win    = a_hit & (~b_hit | ~prio);
  assign b_win    = b_hit & (~a_hit | prio);
  assign grant    = a_win | b_win;
  assign sel_we   = b_win ? b_we : a_we;
  assign rd_go    = grant & ~sel_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio     <= 1'b0;
      en       <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      // priority passes to the loser only when both actually collided
      if (conflict) prio <= ~prio;
      en <= grant;
      we <= grant & sel_we;
      if (grant) begin
        addr  <= b_win ? b_addr  : a_addr;
        wdata <= b_win ? b_wdata : a_wdata;
      end
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_go};
      own_pipe <= {own_pipe[STAGES-1:1], b_win};
    end
  end

  assign rvalid   = vld_pipe[STAGES];
  assign rd_owner = own_pipe[STAGES];
endmodule

module ram_bank_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_bank,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_bank,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  bank1_en,
  output logic                  bank2_en,
  output logic                  bank1_we,
  output logic                  bank2_we,
  output logic [ADDR_WIDTH-1:0] bank1_addr,
  output logic [ADDR_WIDTH-1:0] bank2_addr,
  output logic [DATA_WIDTH-1:0] bank1_wdata,
  output logic [DATA_WIDTH-1:0] bank2_wdata,
  input  logic [DATA_WIDTH-1:0] bank1_rdata,
  input  logic [DATA_WIDTH-1:0] bank2_rdata,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);
  localparam int NUM_BANKS = 2;

  logic [NUM_BANKS-1:0]                 a_hit, b_hit, a_win, b_win, conflict;
  logic [NUM_BANKS-1:0]                 en, we, rvalid, rd_owner, a_rv, b_rv;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wdata, rdata;

  assign rdata = {bank2_rdata, bank1_rdata};

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    localparam logic SEL = (k == 1);
    assign a_hit[k] = a_req & (a_bank == SEL);
    assign b_hit[k] = b_req & (b_bank == SEL);

    ram_bank_lane #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .a_hit    (a_hit[k]),
      .b_hit    (b_hit[k]),
      .a_we     (a_we),
      .b_we     (b_we),
      .a_addr   (a_addr),
      .b_addr   (b_addr),
      .a_wdata  (a_wdata),
      .b_wdata  (b_wdata),
      .a_win    (a_win[k]),
      .b_win    (b_win[k]),
      .conflict (conflict[k]),
      .en       (en[k]),
      .we       (we[k]),
      .addr     (addr[k]),
      .wdata    (wdata[k]),
      .rvalid   (rvalid[k]),
      .rd_owner (rd_owner[k])
    );

    assign a_rv[k] = rvalid[k] & ~rd_owner[k];
    assign b_rv[k] = rvalid[k] &  rd_owner[k];
  end

  assign a_gnt    = |a_win;
  assign b_gnt    = |b_win;
  assign a_rvalid = |a_rv;
  assign b_rvalid = |b_rv;

  // a requester owns at most one bank's return per cycle, so a simple mux suffices
  always_comb begin
    a_rdata = '0;
    b_rdata = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (a_rv[k]) a_rdata = rdata[k];
      if (b_rv[k]) b_rdata = rdata[k];
    end
  end

  assign bank1_en    = en[0];
  assign bank2_en    = en[1];
  assign bank1_we    = we[0];
  assign bank2_we    = we[1];
  assign bank1_addr  = addr[0];
  assign bank2_addr  = addr[1];
  assign bank1_wdata = wdata[0];
  assign bank2_wdata = wdata[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      conflict_cnt <= '0;
    else if (|conflict && !(&conflict_cnt))
      conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Directed bench for ram_bank_arbiter: vector table plus hand sequences for
// round-robin, back-to-back reads, mid-flight reset and counter saturation.
`timescale 1ns/1ps

module tb_ram_bank_arbiter;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       a_req, a_we, a_bank, b_req, b_we, b_bank;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       bank1_en, bank2_en, bank1_we, bank2_we;
  logic [7:0] bank1_addr, bank2_addr, bank1_wdata, bank2_wdata;
  logic [7:0] bank1_rdata = 8'h00, bank2_rdata = 8'h00;
  logic [15:0] conflict_cnt;
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int n_cmp = 0, n_bad = 0;

  ram_bank_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_bank(a_bank), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_bank(b_bank), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .bank1_en(bank1_en), .bank2_en(bank2_en), .bank1_we(bank1_we), .bank2_we(bank2_we),
    .bank1_addr(bank1_addr), .bank2_addr(bank2_addr),
    .bank1_wdata(bank1_wdata), .bank2_wdata(bank2_wdata),
    .bank1_rdata(bank1_rdata), .bank2_rdata(bank2_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // synchronous RAM model, one-cycle read latency
  always @(posedge clk) begin
    if (bank1_en) begin
      if (bank1_we) mem1[bank1_addr] <= bank1_wdata;
      else          bank1_rdata      <= mem1[bank1_addr];
    end
    if (bank2_en) begin
      if (bank2_we) mem2[bank2_addr] <= bank2_wdata;
      else          bank2_rdata      <= mem2[bank2_addr];
    end
  end

  typedef struct {
    logic ar, aw, ab; logic [7:0] aa, ad;
    logic br, bw, bb; logic [7:0] ba, bd;
    logic eag, ebg;
    logic een1, ewe1; logic [7:0] eadr1;
    logic een2, ewe2; logic [7:0] eadr2;
    logic earv; logic [7:0] eard;
    logic ebrv; logic [7:0] ebrd;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_bank = 1'b0; b_bank = 1'b0;
    a_addr = 8'h00; b_addr = 8'h00; a_wdata = 8'h00; b_wdata = 8'h00;
  endtask

  task automatic apply(input vec_t v);
    a_req = v.ar; a_we = v.aw; a_bank = v.ab; a_addr = v.aa; a_wdata = v.ad;
    b_req = v.br; b_we = v.bw; b_bank = v.bb; b_addr = v.ba; b_wdata = v.bd;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'(i + 8'h40);
      mem2[i] = 8'(i + 8'h80);
    end
    //                 A: req we bank addr data   B: req we bank addr data   gnts   bank1        bank2        a rv         b rv         cnt
    vt[0] = '{'1,'0,'0,8'h10,8'h00, '0,'0,'0,8'h00,8'h00, '1,'0, '1,'0,8'h10, '0,'0,8'h00, '1,8'h50, '0,8'h00, 16'd0};
    vt[1] = '{'1,'1,'0,8'h05,8'hAA, '1,'0,'1,8'h07,8'h00, '1,'1, '1,'1,8'h05, '1,'0,8'h07, '0,8'h00, '1,8'h87, 16'd0};
    vt[2] = '{'1,'0,'0,8'h05,8'h00, '0,'0,'0,8'h00,8'h00, '1,'0, '1,'0,8'h05, '0,'0,8'h07, '1,8'hAA, '0,8'h00, 16'd0};
    vt[3] = '{'1,'0,'0,8'h11,8'h00, '1,'0,'0,8'h12,8'h00, '1,'0, '1,'0,8'h11, '0,'0,8'h07, '1,8'h51, '0,8'h00, 16'd1};
    vt[4] = '{'1,'0,'1,8'h20,8'h00, '1,'0,'1,8'h21,8'h00, '1,'0, '0,'0,8'h11, '1,'0,8'h20, '1,8'hA0, '0,8'h00, 16'd2};
    vt[5] = '{'1,'0,'0,8'h13,8'h00, '1,'0,'0,8'h14,8'h00, '0,'1, '1,'0,8'h14, '0,'0,8'h20, '0,8'h00, '1,8'h54, 16'd3};
    vt[6] = '{'0,'0,'0,8'h00,8'h00, '1,'1,'1,8'h30,8'h77, '0,'1, '0,'0,8'h14, '1,'1,8'h30, '0,8'h00, '0,8'h00, 16'd3};
    vt[7] = '{'1,'0,'0,8'h11,8'h00, '1,'0,'1,8'h30,8'h00, '1,'1, '1,'0,8'h11, '1,'0,8'h30, '1,8'h51, '1,8'h77, 16'd3};
    vt[8] = '{'0,'0,'0,8'h00,8'h00, '0,'0,'0,8'h00,8'h00, '0,'0, '0,'0,8'h11, '0,'0,8'h30, '0,8'h00, '0,8'h00, 16'd3};
    vt[9] = '{'1,'1,'1,8'h31,8'h12, '1,'0,'1,8'h31,8'h00, '0,'1, '0,'0,8'h11, '1,'0,8'h31, '0,8'h00, '1,8'hB1, 16'd4};

    // reset with random traffic, then everything must read zero
    idle();
    repeat (3) begin
      @(posedge clk); #1;
      a_req = 1'($urandom); b_req = 1'($urandom); a_bank = 1'($urandom); b_bank = 1'($urandom);
      a_addr = 8'($urandom); b_addr = 8'($urandom); a_we = 1'($urandom); b_we = 1'($urandom);
    end
    idle(); #1;
    chk("rst a_gnt", 32'(a_gnt), 0);        chk("rst b_gnt", 32'(b_gnt), 0);
    chk("rst a_rvalid", 32'(a_rvalid), 0);  chk("rst b_rvalid", 32'(b_rvalid), 0);
    chk("rst a_rdata", 32'(a_rdata), 0);    chk("rst b_rdata", 32'(b_rdata), 0);
    chk("rst bank strobes", 32'({bank1_en, bank1_we, bank2_en, bank2_we}), 0);
    chk("rst bank addr/wdata", 32'({bank1_addr, bank2_addr, bank1_wdata, bank2_wdata}), 0);
    chk("rst conflict_cnt", 32'(conflict_cnt), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // table: first vector lands on the first edge after release
    for (int i = 0; i < 10; i++) begin
      apply(vt[i]);
      @(negedge clk);
      chk($sformatf("v%0d a_gnt", i), 32'(a_gnt), 32'(vt[i].eag));
      chk($sformatf("v%0d b_gnt", i), 32'(b_gnt), 32'(vt[i].ebg));
      @(posedge clk); #1;
      idle();
      chk($sformatf("v%0d bank1_en", i), 32'(bank1_en), 32'(vt[i].een1));
      chk($sformatf("v%0d bank1_we", i), 32'(bank1_we), 32'(vt[i].ewe1));
      chk($sformatf("v%0d bank1_addr", i), 32'(bank1_addr), 32'(vt[i].eadr1));
      chk($sformatf("v%0d bank2_en", i), 32'(bank2_en), 32'(vt[i].een2));
      chk($sformatf("v%0d bank2_we", i), 32'(bank2_we), 32'(vt[i].ewe2));
      chk($sformatf("v%0d bank2_addr", i), 32'(bank2_addr), 32'(vt[i].eadr2));
      @(posedge clk); #1;
      chk($sformatf("v%0d a_rvalid", i), 32'(a_rvalid), 32'(vt[i].earv));
      chk($sformatf("v%0d b_rvalid", i), 32'(b_rvalid), 32'(vt[i].ebrv));
      if (vt[i].earv) chk($sformatf("v%0d a_rdata", i), 32'(a_rdata), 32'(vt[i].eard));
      if (vt[i].ebrv) chk($sformatf("v%0d b_rdata", i), 32'(b_rdata), 32'(vt[i].ebrd));
      chk($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vt[i].ecnt));
    end

    // both hold reads on bank index 1: A, B, A, B
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        a_req = 1'b1; a_bank = 1'b1; a_addr = 8'h40;
        b_req = 1'b1; b_bank = 1'b1; b_addr = 8'h41;
      end else idle();
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("rr%0d a_gnt", i), 32'(a_gnt), 32'(i % 2 == 0));
        chk($sformatf("rr%0d b_gnt", i), 32'(b_gnt), 32'(i % 2 == 1));
      end
      if (i >= 2) begin
        chk($sformatf("rr%0d a_rvalid", i), 32'(a_rvalid), 32'(i % 2 == 0));
        chk($sformatf("rr%0d b_rvalid", i), 32'(b_rvalid), 32'(i % 2 == 1));
        if (i % 2 == 0) chk($sformatf("rr%0d a_rdata", i), 32'(a_rdata), 32'h0C0);
        else            chk($sformatf("rr%0d b_rdata", i), 32'(b_rdata), 32'h0C1);
      end
      @(posedge clk); #1;
    end
    chk("rr conflict_cnt", 32'(conflict_cnt), 4);

    // back-to-back reads of addrs 0..7 on bank index 1
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        idle(); a_req = 1'b1; a_bank = 1'b1; a_addr = 8'(i);
      end else idle();
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("b2b%0d a_rvalid", i), 32'(a_rvalid), 1);
        chk($sformatf("b2b%0d a_rdata", i), 32'(a_rdata), 32'(8'h80 + 8'(i - 2)));
      end else
        chk($sformatf("b2b%0d a_rvalid", i), 32'(a_rvalid), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("b2b tail a_rvalid", 32'(a_rvalid), 0);
    chk("b2b conflict_cnt", 32'(conflict_cnt), 4);

    // reset the cycle after a grant: the pending read must vanish
    @(posedge clk); #1;
    a_req = 1'b1; a_bank = 1'b0; a_addr = 8'h22;
    @(posedge clk); #1;
    idle();
    chk("mid bank1_en before rst", 32'(bank1_en), 1);
    reset_n = 1'b0; #1;
    chk("mid bank1_en in rst", 32'(bank1_en), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid%0d rvalid", i), 32'({a_rvalid, b_rvalid}), 0);
    end
    chk("mid conflict_cnt", 32'(conflict_cnt), 0);

    // continuous bank-0 collision drives the counter into saturation
    @(posedge clk); #1;
    a_req = 1'b1; a_bank = 1'b0; a_addr = 8'h01;
    b_req = 1'b1; b_bank = 1'b0; b_addr = 8'h02;
    repeat (65534) @(posedge clk);
    #1 chk("sat cnt FFFE", 32'(conflict_cnt), 32'hFFFE);
    @(posedge clk); #1;
    chk("sat cnt FFFF", 32'(conflict_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1 chk("sat cnt held", 32'(conflict_cnt), 32'hFFFF);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
